rr_slice_arb: RTL and testbench
===============================

# rr_slice_arb

Time-sliced round-robin arbiter sharing one datapath resource (e.g. a mod-6 up-counter datapath) among NREQ requesters. The block sequences ownership with a registered one-hot grant and bounds each tenure with an internal slice counter. It forces a one-cycle dead handoff between owners, so downstream logic never sees two owners in back-to-back cycles. It sits between the requester agents and the shared resource's enable and select inputs.

## Interface
- NREQ, 4, number of requesters; 2..8.
- SLICE_W, 3, width of the slice counter.
- SLICE_MAX, 5, last slice count value; tenure is SLICE_MAX+1 cycles. SLICE_MAX < 2**SLICE_W; a violation is an elaboration error.
- CLK  in  1  clock; all state changes on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable; low blocks new grants only.
- req  in  NREQ  request vector; bit i held high while requester i wants the resource.
- gnt  out  NREQ  one-hot grant, registered; all-zero when there is no owner.
- gnt_id  out  clog2(NREQ)  index of the current owner; holds its last value when gnt is 0.
- slice_cnt  out  SLICE_W  cycles elapsed in the current tenure; 0 on the first grant cycle.
- preempt  out  1  one-cycle pulse: the previous tenure ended by slice expiry.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE: gnt=0, busy=0.
  - OWN: gnt one-hot, busy=1.
  - HANDOFF: gnt=0, busy=1, lasts exactly 1 cycle.
- Winner search: the first set bit of req scanning ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ). ptr is an internal register.
- IDLE to OWN: when en=1 and req≠0. On entry, gnt/gnt_id = winner and slice_cnt = 0.
- OWN:
  - slice_cnt increments by 1 each cycle.
  - Release: req[gnt_id]=0 at the edge. Go to HANDOFF with preempt=0.
  - Expiry: slice_cnt==SLICE_MAX at the edge while req[gnt_id]=1. Go to HANDOFF with preempt=1.
  - Release and expiry at the same edge count as release, so preempt=0.
  - slice_cnt never wraps within a tenure.
- Entering HANDOFF: ptr = (gnt_id+1) mod NREQ, gnt = 0, slice_cnt = 0.
- HANDOFF exit:
  - en=1 and req≠0: go to OWN with the winner from the new ptr. A sole requester whose slice expired is re-granted.
  - Otherwise go to IDLE.
- en=0 does not revoke a current owner. The tenure completes normally.
- preempt is high only during the HANDOFF cycle.
- Requests are not latched. A req pulse that is low at every sampling edge is never granted.
- Reset values (asynchronous, immediate, also mid-tenure):
  - state = IDLE, gnt = 0, gnt_id = 0, slice_cnt = 0, preempt = 0, busy = 0, ptr = 0.
- After RSTN deasserts, arbitration resumes from ptr = 0.

## Timing
- Grant latency from IDLE: req sampled at edge t gives gnt at edge t (visible the following cycle), 1 cycle.
- Owner drops req before edge t: gnt=0 after edge t; the next owner's gnt appears after edge t+1.
- Maximum tenure is SLICE_MAX+1 cycles, 6 by default. Tenure plus handoff is 7 cycles.
- Worst-case wait for a continuously requesting agent: (NREQ-1)·(SLICE_MAX+2) + 1 cycles, 22 for the defaults.
- All outputs are registered; there are no combinational paths from req or en to outputs.

## Test plan
- **Reset / single grant:** RSTN low → all outputs 0. Release RSTN, then req=4'b0100 at edge 1 → gnt=4'b0100, gnt_id=2 after edge 1, slice_cnt=0. Drop req at edge 4 → gnt=0 with preempt=0, then IDLE one cycle later.
- **Expiry:** req=4'b0010 held for 20 cycles. Required sequence: gnt=0010 for 6 cycles (slice_cnt 0..5), then 1 HANDOFF cycle with preempt=1, then re-grant to 0010. This repeats every 7 cycles.
- **Round robin:** req=4'b1111 held. Grant order is 0,1,2,3,0, each owner for 6 cycles with a 1-cycle gap. gnt is never multi-hot.
- **Simultaneous release and expiry:** the owner drops req at the edge where slice_cnt=5. HANDOFF follows with preempt=0, and ptr advances normally.
- **en gating:** en=0 during OWN, other requesters pending → current tenure completes, then IDLE, busy=0. Raise en → grant after 1 cycle to the requester at or after ptr.
- **Reset mid-tenure:** RSTN pulsed low while gnt_id=3 and slice_cnt=3 → outputs clear asynchronously. After release with req=4'b1001, the first grant goes to 0, because ptr=0.

Source files
------------

// File: rtl/rr_slice_arb.sv
// Time-sliced round-robin arbiter: registered one-hot grant, bounded tenure,
// and a mandatory one-cycle dead handoff between owners.
module rr_slice_arb #(
   parameter int NREQ      = 4,
   parameter int SLICE_W   = 3,
   parameter int SLICE_MAX = 5,
   localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               en,
   input  logic [NREQ-1:0]    req,
   output logic [NREQ-1:0]    gnt,
   output logic [IDW-1:0]     gnt_id,
   output logic [SLICE_W-1:0] slice_cnt,
   output logic               preempt,
   output logic               busy
);

   if (SLICE_MAX >= 2**SLICE_W) begin : g_bad_slice_max
      $error("rr_slice_arb: SLICE_MAX does not fit in SLICE_W bits");
   end

   typedef enum logic [1:0] {IDLE, OWN, HANDOFF} state_t;

   state_t             state_q, state_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic [SLICE_W-1:0] slice_q, slice_d;
   logic               preempt_q, preempt_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [IDW-1:0]     win;
   logic [IDW-1:0]     nextPtr;
   logic               anyReq;

   // Circular first-set search starting at ptr; only meaningful when anyReq.
   always_comb begin
      win = ptr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr_q) + k) % NREQ]) begin
            win = IDW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   assign anyReq  = |req;
   assign nextPtr = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      slice_d   = slice_q;
      preempt_d = 1'b0;
      ptr_d     = ptr_q;
      case (state_q)
         IDLE, HANDOFF: begin
            if (en && anyReq) begin
               state_d  = OWN;
               gnt_d    = NREQ'(1) << win;
               gnt_id_d = win;
               slice_d  = '0;
            end else begin
               state_d  = IDLE;
            end
         end
         OWN: begin
            // A release at the expiry edge wins, so preempt follows the owner's req bit.
            if (!req[gnt_id_q] || (slice_q == SLICE_W'(SLICE_MAX))) begin
               state_d   = HANDOFF;
               preempt_d = req[gnt_id_q];
               ptr_d     = nextPtr;
               gnt_d     = '0;
               slice_d   = '0;
            end else begin
               slice_d   = slice_q + SLICE_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            slice_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         slice_q   <= '0;
         preempt_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         slice_q   <= slice_d;
         preempt_q <= preempt_d;
         ptr_q     <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign slice_cnt = slice_q;
   assign preempt   = preempt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rr_slice_arb.sv
// Directed bench for rr_slice_arb with hand-computed expectations packed as
// {gnt, gnt_id, slice_cnt, preempt, busy}.
module tb_rr_slice_arb;

   logic       CLK;
   logic       RSTN;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic [2:0] slice_cnt;
   logic       preempt;
   logic       busy;

   logic [10:0] obs;
   logic [10:0] exp;
   int passCount  = 0;
   int checkCount = 0;

   rr_slice_arb #(.NREQ(4), .SLICE_W(3), .SLICE_MAX(5)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .slice_cnt (slice_cnt),
      .preempt   (preempt),
      .busy      (busy)
   );

   assign obs = {gnt, gnt_id, slice_cnt, preempt, busy};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RSTN = 1'b0; en = 1'b1; req = 4'b0000;
      tick();
      exp = {4'b0000, 2'd0, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL reset_state: got %h want %h", obs, exp); else passCount++;
      RSTN = 1'b1;
      tick();
      checkCount++; if (obs !== exp) $display("FAIL idle_after_reset: got %h want %h", obs, exp); else passCount++;
      req = 4'b0100;
      tick();
      exp = {4'b0100, 2'd2, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL single_grant: got %h want %h", obs, exp); else passCount++;
      tick();
      tick();
      exp = {4'b0100, 2'd2, 3'd2, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL single_count: got %h want %h", obs, exp); else passCount++;
      req = 4'b0000;
      tick();
      exp = {4'b0000, 2'd2, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL release_handoff: got %h want %h", obs, exp); else passCount++;
      tick();
      exp = {4'b0000, 2'd2, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL release_idle: got %h want %h", obs, exp); else passCount++;
   endtask

   // ptr is 3 on entry; sole requester 1 keeps getting re-granted after expiry.
   task automatic test_expiry();
      req = 4'b0010;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 6; c++) begin
            tick();
            exp = {4'b0010, 2'd1, 3'(c), 1'b0, 1'b1};
            checkCount++; if (obs !== exp) $display("FAIL expiry_own p%0d c%0d: got %h want %h", p, c, obs, exp); else passCount++;
         end
         tick();
         exp = {4'b0000, 2'd1, 3'd0, 1'b1, 1'b1};
         checkCount++; if (obs !== exp) $display("FAIL expiry_handoff p%0d: got %h want %h", p, obs, exp); else passCount++;
      end
      req = 4'b0000;
      tick();
      exp = {4'b0000, 2'd1, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL expiry_idle: got %h want %h", obs, exp); else passCount++;
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      RSTN = 1'b0;
      #2;
      RSTN = 1'b1;
      req = 4'b1111;
      for (int o = 0; o < 5; o++) begin
         for (int c = 0; c < 6; c++) begin
            tick();
            exp = {4'(1 << order[o]), 2'(order[o]), 3'(c), 1'b0, 1'b1};
            checkCount++; if (obs !== exp) $display("FAIL rr_own o%0d c%0d: got %h want %h", o, c, obs, exp); else passCount++;
         end
         tick();
         exp = {4'b0000, 2'(order[o]), 3'd0, 1'b1, 1'b1};
         checkCount++; if (obs !== exp) $display("FAIL rr_handoff o%0d: got %h want %h", o, obs, exp); else passCount++;
      end
      req = 4'b0000;
      tick();
      exp = {4'b0000, 2'd0, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL rr_idle: got %h want %h", obs, exp); else passCount++;
   endtask

   // ptr is 1 on entry.
   task automatic test_release_at_expiry();
      req = 4'b0100;
      for (int c = 0; c < 6; c++) begin
         tick();
         exp = {4'b0100, 2'd2, 3'(c), 1'b0, 1'b1};
         checkCount++; if (obs !== exp) $display("FAIL simul_own c%0d: got %h want %h", c, obs, exp); else passCount++;
      end
      req = 4'b0000;
      tick();
      exp = {4'b0000, 2'd2, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL simul_no_preempt: got %h want %h", obs, exp); else passCount++;
      req = 4'b0101;
      tick();
      exp = {4'b0001, 2'd0, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL simul_ptr_advance: got %h want %h", obs, exp); else passCount++;
      req = 4'b0000;
      tick();
      tick();
      exp = {4'b0000, 2'd0, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL simul_idle: got %h want %h", obs, exp); else passCount++;
   endtask

   // ptr is 1 on entry; ends with requester 3 owning at slice_cnt 3.
   task automatic test_en_gating();
      req = 4'b1001;
      tick();
      exp = {4'b1000, 2'd3, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL en_grant: got %h want %h", obs, exp); else passCount++;
      en = 1'b0;
      for (int c = 1; c < 6; c++) begin
         tick();
         exp = {4'b1000, 2'd3, 3'(c), 1'b0, 1'b1};
         checkCount++; if (obs !== exp) $display("FAIL en_keep_owner c%0d: got %h want %h", c, obs, exp); else passCount++;
      end
      tick();
      exp = {4'b0000, 2'd3, 3'd0, 1'b1, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL en_handoff: got %h want %h", obs, exp); else passCount++;
      tick();
      exp = {4'b0000, 2'd3, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL en_blocked_idle: got %h want %h", obs, exp); else passCount++;
      tick();
      checkCount++; if (obs !== exp) $display("FAIL en_still_idle: got %h want %h", obs, exp); else passCount++;
      en = 1'b1;
      tick();
      exp = {4'b0001, 2'd0, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL en_resume_grant: got %h want %h", obs, exp); else passCount++;
      req = 4'b0000;
      tick();
      req = 4'b1000;
      tick();
      tick();
      tick();
      tick();
      exp = {4'b1000, 2'd3, 3'd3, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL mid_setup: got %h want %h", obs, exp); else passCount++;
   endtask

   task automatic test_reset_mid_tenure();
      #2;
      RSTN = 1'b0;
      #1;
      exp = {4'b0000, 2'd0, 3'd0, 1'b0, 1'b0};
      checkCount++; if (obs !== exp) $display("FAIL async_clear: got %h want %h", obs, exp); else passCount++;
      tick();
      checkCount++; if (obs !== exp) $display("FAIL held_in_reset: got %h want %h", obs, exp); else passCount++;
      req = 4'b1001;
      RSTN = 1'b1;
      tick();
      exp = {4'b0001, 2'd0, 3'd0, 1'b0, 1'b1};
      checkCount++; if (obs !== exp) $display("FAIL post_reset_ptr0: got %h want %h", obs, exp); else passCount++;
      req = 4'b0000;
      tick();
   endtask

   initial begin
      test_reset();
      test_expiry();
      test_round_robin();
      test_release_at_expiry();
      test_en_gating();
      test_reset_mid_tenure();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
